// File: rtl/mac_seq_nbit.sv
// Sequential unsigned multiply-accumulate: one CHUNKxCHUNK multiplier is reused over
// (WIDTH/CHUNK)^2 cycles, then the product is loaded into or added to a wrapping accumulator.
module mac_seq_nbit #(
  parameter int WIDTH     = 16,
  parameter int CHUNK     = 8,
  parameter int ACC_WIDTH = 2*WIDTH+8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   acc_en,
  input  logic                   clear,
  input  logic [WIDTH-1:0]       a,
  input  logic [WIDTH-1:0]       b,
  output logic                   busy,
  output logic                   done,
  output logic [2*WIDTH-1:0]     product,
  output logic [ACC_WIDTH-1:0]   acc,
  output logic                   ovf
);
  localparam int N     = WIDTH / CHUNK;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                 state_q, state_d;
  logic [WIDTH-1:0]       a_q, a_d, b_q, b_d;
  logic                   acc_en_q, acc_en_d;
  logic [IDX_W-1:0]       i_q, i_d, j_q, j_d;
  logic [2*WIDTH-1:0]     partial_q, partial_d;
  logic [2*WIDTH-1:0]     product_q, product_d;
  logic [ACC_WIDTH-1:0]   acc_q, acc_d;
  logic                   ovf_q, ovf_d;
  logic                   busy_q, busy_d, done_q, done_d;

  logic [CHUNK-1:0]       a_slice, b_slice;
  logic [2*CHUNK-1:0]     pp;
  logic [31:0]            shamt;
  logic [2*WIDTH-1:0]     pp_shift;
  logic [ACC_WIDTH:0]     acc_sum;
  logic                   last_step;

  assign a_slice   = a_q[int'(i_q)*CHUNK +: CHUNK];
  assign b_slice   = b_q[int'(j_q)*CHUNK +: CHUNK];
  assign pp        = {{CHUNK{1'b0}}, a_slice} * {{CHUNK{1'b0}}, b_slice};
  assign shamt     = 32'((int'(i_q) + int'(j_q)) * CHUNK);
  assign pp_shift  = (2*WIDTH)'(pp) << shamt;
  // Extra MSB captures the carry out of the accumulator for the sticky overflow.
  assign acc_sum   = {1'b0, acc_q} + {1'b0, ACC_WIDTH'(partial_q)};
  assign last_step = (i_q == LAST) && (j_q == LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      acc_en_q  <= 1'b0;
      i_q       <= '0;
      j_q       <= '0;
      partial_q <= '0;
      product_q <= '0;
      acc_q     <= '0;
      ovf_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      acc_en_q  <= acc_en_d;
      i_q       <= i_d;
      j_q       <= j_d;
      partial_q <= partial_d;
      product_q <= product_d;
      acc_q     <= acc_d;
      ovf_q     <= ovf_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last_step) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    a_d       = a_q;
    b_d       = b_q;
    acc_en_d  = acc_en_q;
    i_d       = i_q;
    j_d       = j_q;
    partial_d = partial_q;
    product_d = product_q;
    acc_d     = acc_q;
    ovf_d     = ovf_q;
    busy_d    = (state_d != IDLE);
    done_d    = (state_d == DONE);
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d       = a;
          b_d       = b;
          acc_en_d  = acc_en;
          partial_d = '0;
          i_d       = '0;
          j_d       = '0;
        end
      end
      RUN: begin
        partial_d = partial_q + pp_shift;
        if (j_q == LAST) begin
          j_d = '0;
          i_d = i_q + 1'b1;
        end else begin
          j_d = j_q + 1'b1;
        end
      end
      DONE: begin
        product_d = partial_q;
        if (acc_en_q) begin
          acc_d = acc_sum[ACC_WIDTH-1:0];
          if (acc_sum[ACC_WIDTH]) ovf_d = 1'b1;
        end else begin
          acc_d = ACC_WIDTH'(partial_q);
        end
      end
      default: ;
    endcase
    // clear wins over the DONE update of acc/ovf; product is unaffected.
    if (clear) begin
      acc_d = '0;
      ovf_d = 1'b0;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = product_q;
  assign acc     = acc_q;
  assign ovf     = ovf_q;
endmodule

// File: tb/tb_mac_seq_nbit.sv
// Bench for mac_seq_nbit: default, narrow-accumulator and 32-bit instances, with table,
// hand-written corner sequences and random operations against an arithmetic reference model.
module tb_mac_seq_nbit;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic start0, en0, clr0, busy0, done0, ovf0;
  logic [15:0] a0, b0;
  logic [31:0] prod0;
  logic [39:0] acc0;

  logic start1, en1, clr1, busy1, done1, ovf1;
  logic [15:0] a1, b1;
  logic [31:0] prod1;
  logic [32:0] acc1;

  logic start2, en2, clr2, busy2, done2, ovf2;
  logic [31:0] a2, b2;
  logic [63:0] prod2;
  logic [71:0] acc2;

  mac_seq_nbit dut0 (
    .clk(clk), .reset(rst), .start(start0), .acc_en(en0), .clear(clr0), .a(a0), .b(b0),
    .busy(busy0), .done(done0), .product(prod0), .acc(acc0), .ovf(ovf0));

  mac_seq_nbit #(.WIDTH(16), .CHUNK(8), .ACC_WIDTH(33)) dut1 (
    .clk(clk), .reset(rst), .start(start1), .acc_en(en1), .clear(clr1), .a(a1), .b(b1),
    .busy(busy1), .done(done1), .product(prod1), .acc(acc1), .ovf(ovf1));

  mac_seq_nbit #(.WIDTH(32), .CHUNK(8)) dut2 (
    .clk(clk), .reset(rst), .start(start2), .acc_en(en2), .clear(clr2), .a(a2), .b(b2),
    .busy(busy2), .done(done2), .product(prod2), .acc(acc2), .ovf(ovf2));

  int checks = 0;
  int errors = 0;

  logic [39:0] m_acc;
  logic        m_ovf;
  logic [31:0] m_prod;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    bit          en;
    logic [31:0] prod;
  } vec_t;
  vec_t vecs[7];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic model_op(input logic [15:0] aa, input logic [15:0] bb, input bit en);
    logic [40:0] s;
    m_prod = 32'(aa) * 32'(bb);
    if (en) begin
      s = {1'b0, m_acc} + 41'(m_prod);
      m_acc = s[39:0];
      if (s[40]) m_ovf = 1'b1;
    end else begin
      m_acc = 40'(m_prod);
    end
  endtask

  // Called at a negedge; returns at the negedge of the first cycle after done.
  task automatic op0(input logic [15:0] aa, input logic [15:0] bb, input bit en, input bit scramble);
    int lat;
    a0 = aa; b0 = bb; en0 = en; start0 = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      start0 = 1'b0;
      lat++;
      if (lat == 1) chk("busy_in_run", busy0, 1'b1);
      if (scramble) begin
        a0 = 16'($urandom); b0 = 16'($urandom); en0 = 1'($urandom);
      end
    end while (!done0 && lat < 50);
    chk("latency", lat, 5);
    model_op(aa, bb, en);
    @(negedge clk);
    chk("product", prod0, m_prod);
    chk("acc", acc0, m_acc);
    chk("ovf", ovf0, m_ovf);
    chk("busy_after", busy0, 1'b0);
    chk("done_pulse", done0, 1'b0);
    $display("op a=%h b=%h acc_en=%0d product=%h acc=%h ovf=%0d", aa, bb, en, prod0, acc0, ovf0);
  endtask

  task automatic clear0();
    clr0 = 1'b1;
    @(negedge clk);
    clr0 = 1'b0;
    m_acc = '0; m_ovf = 1'b0;
    chk("clear_acc", acc0, 40'h0);
    chk("clear_ovf", ovf0, 1'b0);
    $display("clear acc=%h ovf=%0d", acc0, ovf0);
  endtask

  task automatic op1(input logic [15:0] aa, input logic [15:0] bb, input bit en);
    int lat;
    a1 = aa; b1 = bb; en1 = en; start1 = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      start1 = 1'b0;
      lat++;
    end while (!done1 && lat < 50);
    chk("w33_latency", lat, 5);
    @(negedge clk);
    $display("op33 a=%h b=%h acc_en=%0d product=%h acc=%h ovf=%0d", aa, bb, en, prod1, acc1, ovf1);
  endtask

  task automatic op2(input logic [31:0] aa, input logic [31:0] bb, input bit en, input bit clr_at_done);
    int lat;
    a2 = aa; b2 = bb; en2 = en; start2 = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      start2 = 1'b0;
      lat++;
    end while (!done2 && lat < 100);
    chk("w32_latency", lat, 17);
    if (clr_at_done) clr2 = 1'b1;
    @(negedge clk);
    clr2 = 1'b0;
    $display("op32 a=%h b=%h acc_en=%0d product=%h acc=%h ovf=%0d", aa, bb, en, prod2, acc2, ovf2);
  endtask

  initial begin
    int dcount, dcyc, lat;
    vecs[0] = '{16'h1234, 16'h5678, 1'b0, 32'h06260060};
    vecs[1] = '{16'hFFFF, 16'hFFFF, 1'b1, 32'hFFFE0001};
    vecs[2] = '{16'h0003, 16'h0005, 1'b1, 32'h0000000F};
    vecs[3] = '{16'h0000, 16'hFFFF, 1'b1, 32'h00000000};
    vecs[4] = '{16'h0100, 16'h0100, 1'b0, 32'h00010000};
    vecs[5] = '{16'h8000, 16'h0002, 1'b1, 32'h00010000};
    vecs[6] = '{16'hFFFF, 16'h0001, 1'b1, 32'h0000FFFF};

    {start0, en0, clr0, a0, b0} = '0;
    {start1, en1, clr1, a1, b1} = '0;
    {start2, en2, clr2, a2, b2} = '0;
    m_acc = '0; m_ovf = 1'b0; m_prod = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_busy", busy0, 1'b0);
    chk("rst_done", done0, 1'b0);
    chk("rst_product", prod0, 32'h0);
    chk("rst_acc", acc0, 40'h0);
    chk("rst_ovf", ovf0, 1'b0);

    // Narrow accumulator: wrap and sticky overflow.
    op1(16'hFFFF, 16'hFFFF, 1'b1);
    op1(16'hFFFF, 16'hFFFF, 1'b1);
    chk("w33_acc2", acc1, 33'h1FFFC0002);
    chk("w33_ovf2", ovf1, 1'b0);
    op1(16'hFFFF, 16'hFFFF, 1'b1);
    chk("w33_prod3", prod1, 32'hFFFE0001);
    chk("w33_acc3", acc1, 33'h0FFFA0003);
    chk("w33_ovf3", ovf1, 1'b1);
    op1(16'h0003, 16'h0005, 1'b0);
    chk("w33_load_acc", acc1, 33'h0000000F);
    chk("w33_load_ovf", ovf1, 1'b1);
    clr1 = 1'b1;
    @(negedge clk);
    clr1 = 1'b0;
    chk("w33_clear_acc", acc1, 33'h0);
    chk("w33_clear_ovf", ovf1, 1'b0);

    // 32-bit operands; clear coinciding with done.
    op2(32'h3, 32'h5, 1'b0, 1'b0);
    chk("w32_load_acc", acc2, 72'hF);
    op2(32'hFFFFFFFF, 32'h2, 1'b1, 1'b1);
    chk("w32_product", prod2, 64'h1FFFFFFFE);
    chk("w32_clear_acc", acc2, 72'h0);
    chk("w32_clear_ovf", ovf2, 1'b0);

    // Main plan on the default instance.
    op0(16'h1234, 16'h5678, 1'b0, 1'b0);
    chk("plan_product", prod0, 32'h06260060);
    chk("plan_acc", acc0, 40'h0006260060);
    clear0();
    op0(16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
    op0(16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
    chk("b2b_product", prod0, 32'hFFFE0001);
    chk("b2b_acc", acc0, 40'h01FFFC0002);

    // start held high throughout a run.
    a0 = 16'd3; b0 = 16'd5; en0 = 1'b0; start0 = 1'b1;
    dcount = 0; dcyc = 0;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (done0) begin dcount++; dcyc = c; end
    end
    chk("hold_start_dones", dcount, 1);
    chk("hold_start_done_cycle", dcyc, 5);
    model_op(16'd3, 16'd5, 1'b0);
    @(negedge clk);
    chk("hold_start_product", prod0, 32'd15);
    chk("hold_start_idle", busy0, 1'b0);
    @(negedge clk);
    start0 = 1'b0;
    chk("hold_start_restart", busy0, 1'b1);
    lat = 0;
    while (!done0 && lat < 50) begin @(negedge clk); lat++; end
    chk("hold_start_second_done", done0, 1'b1);
    model_op(16'd3, 16'd5, 1'b0);
    @(negedge clk);
    chk("hold_start_second_acc", acc0, m_acc);
    $display("hold-start product=%h acc=%h", prod0, acc0);

    // Table vectors, with inputs scrambled after the start cycle.
    for (int k = 0; k < 7; k++) begin
      op0(vecs[k].a, vecs[k].b, vecs[k].en, 1'b1);
      chk("table_product", prod0, vecs[k].prod);
    end

    // Random operations against the reference model.
    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 7) == 0) clear0();
      op0(16'($urandom), 16'($urandom), 1'($urandom_range(0, 3) != 0), 1'b1);
    end

    // Reset two cycles into a run.
    a0 = 16'h1234; b0 = 16'h5678; en0 = 1'b1; start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_acc = '0; m_ovf = 1'b0; m_prod = '0;
    chk("midrst_busy", busy0, 1'b0);
    chk("midrst_done", done0, 1'b0);
    chk("midrst_acc", acc0, m_acc);
    chk("midrst_product", prod0, m_prod);
    chk("midrst_ovf", ovf0, m_ovf);
    dcount = 0;
    repeat (8) begin
      @(negedge clk);
      if (done0) dcount++;
    end
    chk("midrst_no_done", dcount, 0);
    $display("mid-run reset busy=%0d acc=%h product=%h", busy0, acc0, prod0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mac_seq_nbit.md
# mac_seq_nbit

Sequential, parametrised unsigned multiply-accumulate unit for the MAC datapath. It extends the fixed 16×16 combinational multiplier to any WIDTH that is a multiple of CHUNK. It uses one CHUNK×CHUNK partial-product multiplier, time-multiplexed over (WIDTH/CHUNK)² cycles, in place of a parallel array. The final product is either loaded into, or added to, a wrapping accumulator that carries a sticky overflow flag.

## Interface
- WIDTH, 16, operand width in bits; must be an integer multiple of CHUNK.
- CHUNK, 8, partial-product slice width in bits.
- ACC_WIDTH, 2*WIDTH+8, accumulator width in bits; must be ≥ 2*WIDTH.
- clk  input  1  single clock; every register updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request a new operation; accepted only in IDLE.
- acc_en  input  1  sampled with start: 1 = accumulate, 0 = load.
- clear  input  1  zeroes acc and ovf.
- a  input  WIDTH  multiplicand, sampled on the accepted start.
- b  input  WIDTH  multiplier, sampled on the accepted start.
- busy  output  1  high while in RUN or DONE.
- done  output  1  one-cycle pulse when product and acc are updated.
- product  output  2*WIDTH  last completed product; held until the next done.
- acc  output  ACC_WIDTH  accumulator.
- ovf  output  1  sticky flag, set when an accumulate carries out of ACC_WIDTH.

## Operation
- N = WIDTH/CHUNK. Slice k of a is a[(k+1)*CHUNK-1 : k*CHUNK]; b is sliced the same way.
- FSM states: IDLE, RUN, DONE.
- IDLE → RUN on start:
  - a, b and acc_en are registered.
  - The partial register (2*WIDTH bits) is cleared.
  - Indices i=0 and j=0 are set.
- RUN, one step per cycle:
  - partial += (a_i × b_j) << ((i+j)*CHUNK).
  - j advances fastest: j increments and wraps to 0, and i increments when j wraps.
  - After the step with i=j=N-1, the FSM moves to DONE.
  - RUN lasts exactly N² cycles.
- DONE, for one cycle:
  - product ← partial.
  - If acc_en, acc ← (acc + partial) mod 2^ACC_WIDTH, and ovf is set if the addition carries out.
  - If not acc_en, acc ← zero-extended partial; ovf is unchanged.
  - done = 1 for this cycle.
  - Next state is IDLE.
- Arithmetic:
  - Unsigned only.
  - The partial sum never exceeds (2^WIDTH−1)², so no carry is lost within 2*WIDTH bits.
- Boundary rules:
  - start while busy is ignored; no queuing.
  - clear has priority over the DONE update of acc and ovf. If both occur in the same cycle, acc=0 and ovf=0, and product is still updated.
  - clear is effective in any state.
  - a, b and acc_en may change freely after the start cycle.
  - reset in any state:
    - FSM returns to IDLE.
    - busy, done and ovf go to 0.
    - product and acc go to 0.
    - Any in-flight operation is discarded with no done.

## Timing
- Reset values: busy=0, done=0, product=0, acc=0, ovf=0, FSM=IDLE.
- start is sampled high in IDLE at edge 0.
- busy is high from cycle 1 through cycle N²+1.
- done is high in cycle N²+1; product, acc and ovf hold their new values from cycle N²+2.
- With default parameters (N=2): 4 RUN cycles, and done is asserted 5 cycles after start.
- A new start may be sampled in the cycle after done. Back-to-back throughput is one result per N²+2 cycles.
- All outputs are registered, with no combinational path from input to output.

## Test plan
- Reset, then a=0x1234, b=0x5678, acc_en=0, start pulse -> done exactly 5 cycles later, product=0x06260060, acc=0x0006260060, ovf=0.
- a=0xFFFF, b=0xFFFF, acc_en=1, run twice from acc=0 -> product=0xFFFE0001 each time; acc=0x1FFFC0002 after the second done; busy is low for one cycle between the runs.
- ACC_WIDTH=33, three accumulates of 0xFFFF×0xFFFF -> acc=0x0FFFA0003 and ovf=1 after the third done; ovf stays 1 through a following load; clear -> acc=0, ovf=0.
- start re-asserted on every cycle of a run (a=3, b=5) -> exactly one done with product=15; a second operation begins only after IDLE is re-entered.
- reset asserted two cycles into a run -> next cycle busy=0, done=0, acc=0, product=0; no done pulse follows.
- WIDTH=32, CHUNK=8, a=0xFFFFFFFF, b=0x00000002 -> done 17 cycles after start, product=0x1FFFFFFFE; clear and done in the same cycle -> acc=0, product is still updated.
